// File: rtl/sdam_write_scheduler.sv
// Round-robin write arbiter and serial master for the SDAM-style scl/sda write link.
// Four requesters share one free-running scl; each grant becomes one 26-bit frame plus idle gap.
module sdam_write_scheduler #(
    parameter int unsigned SCL_HALF   = 2,
    parameter int unsigned GAP_BITS   = 2,
    parameter int unsigned FLUSH_BITS = 28
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [31:0] addr_in,
    input  logic [63:0] data_in,
    output logic [3:0]  grant,
    output logic        busy,
    output logic        done,
    output logic [1:0]  done_id,
    output logic        scl,
    output logic        sda
);

    localparam int unsigned DivW   = (SCL_HALF > 1) ? $clog2(SCL_HALF) : 1;
    localparam int unsigned GapW   = $clog2(GAP_BITS + 1);
    localparam int unsigned FlushW = (FLUSH_BITS > 1) ? $clog2(FLUSH_BITS + 1) : 1;

    localparam logic [DivW-1:0]   DivLast   = DivW'(SCL_HALF - 1);
    localparam logic [GapW-1:0]   GapLast   = GapW'(GAP_BITS - 1);
    localparam logic [FlushW-1:0] FlushLast = FlushW'(FLUSH_BITS - 1);
    localparam logic [4:0]        LastBit   = 5'd25;

    typedef enum logic [1:0] {StFlush, StIdle, StShift, StGap} state_e;

    state_e              state_q;
    logic [DivW-1:0]     div_q;
    logic                scl_q;
    logic                sda_q;
    logic [3:0]          grant_q;
    logic                busy_q;
    logic                done_q;
    logic [1:0]          done_id_q;
    logic [FlushW-1:0]   flush_cnt_q;
    logic [GapW-1:0]     gap_cnt_q;
    logic [4:0]          bit_cnt_q;
    logic [1:0]          ptr_q;
    logic [1:0]          win_q;
    logic [23:0]         sreg_q;

    logic                div_wrap;
    logic                fall_tick;
    logic                win_found;
    logic [1:0]          win_idx;
    logic [1:0]          cand;

    assign div_wrap  = (div_q == DivLast);
    assign fall_tick = div_wrap && scl_q;

    // Scan upward from the requester after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StFlush;
            div_q       <= '0;
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            grant_q     <= 4'b0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= 2'd0;
            flush_cnt_q <= '0;
            gap_cnt_q   <= '0;
            bit_cnt_q   <= 5'd0;
            ptr_q       <= 2'd3;
            win_q       <= 2'd0;
            sreg_q      <= 24'd0;
        end else begin
            grant_q <= 4'b0000;
            done_q  <= 1'b0;
            // busy stays high through the done cycle and drops one clk later.
            if (done_q) begin
                busy_q <= 1'b0;
            end

            if (div_wrap) begin
                div_q <= '0;
                scl_q <= ~scl_q;
            end else begin
                div_q <= div_q + 1'b1;
            end

            if (fall_tick) begin
                unique case (state_q)
                    StFlush: begin
                        sda_q <= 1'b1;
                        if (FLUSH_BITS == 0 || flush_cnt_q == FlushLast) begin
                            state_q <= StIdle;
                        end else begin
                            flush_cnt_q <= flush_cnt_q + 1'b1;
                        end
                    end
                    StIdle: begin
                        sda_q <= 1'b1;
                        if (win_found) begin
                            ptr_q     <= win_idx;
                            win_q     <= win_idx;
                            grant_q   <= 4'b0001 << win_idx;
                            busy_q    <= 1'b1;
                            sda_q     <= 1'b0;
                            sreg_q    <= {data_in[{win_idx, 4'b0000} +: 16],
                                          addr_in[{win_idx, 3'b000} +: 8]};
                            bit_cnt_q <= 5'd0;
                            state_q   <= StShift;
                        end
                    end
                    StShift: begin
                        if (bit_cnt_q == LastBit) begin
                            sda_q     <= 1'b1;
                            gap_cnt_q <= '0;
                            state_q   <= StGap;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            // Bit 1 is the write-mode flag; payload follows LSB first.
                            if (bit_cnt_q == 5'd0) begin
                                sda_q <= 1'b1;
                            end else begin
                                sda_q  <= sreg_q[0];
                                sreg_q <= {1'b0, sreg_q[23:1]};
                            end
                        end
                    end
                    StGap: begin
                        sda_q <= 1'b1;
                        if (gap_cnt_q == GapLast) begin
                            done_q    <= 1'b1;
                            done_id_q <= win_q;
                            state_q   <= StIdle;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= StFlush;
                endcase
            end
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign scl     = scl_q;
    assign sda     = sda_q;

endmodule
